// File: rtl/uart_rx_sampler_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler_if
// Purpose  : Receive-side byte delivery bundle from the UART sampler.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
        input busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Purpose  : 8N1 UART receiver, oversampled with 3-sample mid-bit majority vote.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int MID        = 8
) (
    input wire                  sys_clk,
    input wire                  reset,
    input wire                  smp_clk,
    input wire                  rx,
    uart_rx_sampler_if.master   rx_if
);
    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TCW-1:0] c_TICK_EARLY = TCW'(MID - 1);
    localparam logic [TCW-1:0] c_TICK_MID   = TCW'(MID);
    localparam logic [TCW-1:0] c_TICK_VOTE  = TCW'(MID + 1);
    localparam logic [TCW-1:0] c_TICK_LAST  = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] c_TCNT_ONE   = TCW'(1);
    localparam logic [BCW-1:0] c_BIT_LAST   = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] c_BCNT_ONE   = BCW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic                   r_smp_d;
    logic [TCW-1:0]         r_tcnt;
    logic [BCW-1:0]         r_bcnt;
    logic                   r_v0;
    logic                   r_v1;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;

    logic                   w_tick;
    logic                   w_vote;
    logic                   w_at_vote;
    logic                   w_at_last;
    logic [TCW-1:0]         w_tcnt_next;

    // Sync flops idle high so reset does not look like a start edge.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_smp_d   <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_smp_d   <= smp_clk;
        end
    end

    assign w_tick      = smp_clk & ~r_smp_d;
    assign w_vote      = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);
    assign w_at_vote   = (r_tcnt == c_TICK_VOTE);
    assign w_at_last   = (r_tcnt == c_TICK_LAST);
    assign w_tcnt_next = w_at_last ? '0 : r_tcnt + c_TCNT_ONE;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            r_bcnt      <= '0;
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_tick) begin
                if (r_tcnt == c_TICK_EARLY) r_v0 <= r_rx_s;
                if (r_tcnt == c_TICK_MID)   r_v1 <= r_rx_s;
                case (r_state)
                    S_IDLE: begin
                        if (!r_rx_s) begin
                            r_state <= S_START;
                            r_tcnt  <= '0;
                            r_bcnt  <= '0;
                        end
                    end
                    S_START: begin
                        if (w_at_vote && w_vote) begin
                            r_state <= S_IDLE;
                            r_tcnt  <= '0;
                        end else begin
                            r_tcnt <= w_tcnt_next;
                            if (w_at_last) begin
                                r_state <= S_DATA;
                                r_bcnt  <= '0;
                            end
                        end
                    end
                    S_DATA: begin
                        r_tcnt <= w_tcnt_next;
                        if (w_at_vote)
                            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (w_at_last) begin
                            if (r_bcnt == c_BIT_LAST)
                                r_state <= S_STOP;
                            else
                                r_bcnt <= r_bcnt + c_BCNT_ONE;
                        end
                    end
                    S_STOP: begin
                        // Decide mid-stop so a back-to-back start edge is not missed.
                        if (w_at_vote) begin
                            r_tcnt <= '0;
                            if (w_vote) begin
                                r_rx_data   <= r_shift;
                                r_rx_valid  <= 1'b1;
                                r_frame_err <= 1'b0;
                                r_state     <= S_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_BREAK;
                            end
                        end else begin
                            r_tcnt <= w_tcnt_next;
                        end
                    end
                    S_BREAK: begin
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                            r_tcnt  <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_if.rx_data   = r_rx_data;
    assign rx_if.rx_valid  = r_rx_valid;
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_sampler
// Purpose  : Directed frames into uart_rx_sampler with queue-based checking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sampler;
    localparam int BIT_CYC = 64;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b0;
    logic       rx      = 1'b1;
    logic [1:0] div     = 2'd0;
    logic       smp_clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       prev_valid = 1'b0;
    logic       prev_busy  = 1'b0;

    uart_rx_sampler_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_sampler #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .MID        (8)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .smp_clk (smp_clk),
        .rx      (rx),
        .rx_if   (rx_if)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) div <= div + 2'd1;
    assign smp_clk = div[1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every rx_valid pops the oldest expected byte.
    always @(negedge sys_clk) begin
        if (reset && rx_if.rx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: actual rx_data=%0h required no rx_valid", rx_if.rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_data_at_valid", 32'(rx_if.rx_data), 32'(mon_exp));
            end
            check("frame_err_at_valid", 32'(rx_if.frame_err), 32'd0);
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
            check("busy_fall_with_valid", {30'd0, prev_busy, rx_if.busy}, 32'b10);
        end
        prev_valid = rx_if.rx_valid;
        prev_busy  = rx_if.busy;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CYC) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) exp_q.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    initial begin
        logic [7:0] partial;
        repeat (5) @(posedge sys_clk);
        #1;
        check("reset_rx_data",   32'(rx_if.rx_data),   32'd0);
        check("reset_rx_valid",  32'(rx_if.rx_valid),  32'd0);
        check("reset_frame_err", 32'(rx_if.frame_err), 32'd0);
        check("reset_busy",      32'(rx_if.busy),      32'd0);
        reset = 1'b1;
        drive_bit(1'b1);

        send_byte(8'h55, 1'b1);
        drive_bit(1'b1);
        check("good_55_data", 32'(rx_if.rx_data),   32'h55);
        check("good_55_ferr", 32'(rx_if.frame_err), 32'd0);
        check("good_55_busy", 32'(rx_if.busy),      32'd0);

        // Bad stop bit: line stays low past the stop slot.
        send_byte(8'hA3, 1'b0);
        check("bad_stop_ferr", 32'(rx_if.frame_err), 32'd1);
        check("bad_stop_data", 32'(rx_if.rx_data),   32'h55);
        check("break_busy",    32'(rx_if.busy),      32'd1);
        drive_bit(1'b1);
        check("break_exit_busy", 32'(rx_if.busy),      32'd0);
        check("break_ferr_held", 32'(rx_if.frame_err), 32'd1);
        send_byte(8'h3C, 1'b1);
        drive_bit(1'b1);
        check("good_3c_data", 32'(rx_if.rx_data),   32'h3C);
        check("good_3c_ferr", 32'(rx_if.frame_err), 32'd0);

        // False start: low for 4 ticks only.
        rx = 1'b0;
        repeat (16) @(posedge sys_clk);
        #1;
        rx = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        check("false_start_busy_hi", 32'(rx_if.busy), 32'd1);
        repeat (30) @(posedge sys_clk);
        #1;
        check("false_start_busy_lo", 32'(rx_if.busy),    32'd0);
        check("false_start_data",    32'(rx_if.rx_data), 32'h3C);
        drive_bit(1'b1);

        // 0xFF with a one-tick low glitch on the centre tick of data bit 0.
        exp_q.push_back(8'hFF);
        drive_bit(1'b0);
        rx = 1'b1;
        repeat (32) @(posedge sys_clk);
        #1;
        rx = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        rx = 1'b1;
        repeat (28) @(posedge sys_clk);
        #1;
        for (int i = 1; i < 8; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("glitch_ff_data", 32'(rx_if.rx_data), 32'hFF);

        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        drive_bit(1'b1);
        check("b2b_last_data", 32'(rx_if.rx_data), 32'hFF);

        // Reset in the middle of data bit 4 of 0x81.
        partial = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        rx = partial[4];
        repeat (32) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("midreset_data",  32'(rx_if.rx_data),   32'd0);
        check("midreset_busy",  32'(rx_if.busy),      32'd0);
        check("midreset_valid", 32'(rx_if.rx_valid),  32'd0);
        check("midreset_ferr",  32'(rx_if.frame_err), 32'd0);
        reset = 1'b1;
        drive_bit(1'b1);
        send_byte(8'h7E, 1'b1);
        drive_bit(1'b1);
        check("after_reset_7e_data", 32'(rx_if.rx_data), 32'h7E);

        check("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
